// File: rtl/count_seq.sv
// Interval sequencer driving an external load/enable counter; emits a tick when cnt_out hits the period.
// Optional prescaler enabled with `define COUNT_SEQ_PRESCALE_EN.
module count_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] cnt_out,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [7:0]       prescale,
`endif
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic [WIDTH-1:0] r_period;
  logic             r_tick;
  logic             w_latch;
  logic             w_term;
  logic             w_load;
  logic             w_enab;
  logic             w_pre_ok;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [7:0] r_scale;
  logic [7:0] r_pre;

  always_comb begin
    w_pre_ok = (r_pre == 8'd0);
  end

  // Prescaler: reload on every counter load, otherwise count down and reload at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scale <= 8'd0;
      r_pre   <= 8'd0;
    end else begin
      if (w_latch) begin
        r_scale <= prescale;
      end
      if (w_load) begin
        r_pre <= r_scale;
      end else if (r_state == ST_RUN) begin
        if (r_pre != 8'd0) begin
          r_pre <= r_pre - 8'd1;
        end else begin
          r_pre <= r_scale;
        end
      end else begin
        r_pre <= r_pre;
      end
    end
  end
`else
  always_comb begin
    w_pre_ok = 1'b1;
  end
`endif

  // Next-state decode; also flags when run parameters are captured.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_LOAD;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop || (w_term && !r_mode)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter control decodes; stop kills both load and enable while running.
  always_comb begin
    w_term = (r_state == ST_RUN) && (cnt_out == r_period);
    w_load = (r_state == ST_LOAD) || (w_term && r_mode && !stop);
    w_enab = (r_state == ST_RUN) && !w_term && !stop && w_pre_ok;
  end

  // State, latched run parameters and the expiry pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= 1'b0;
      r_period <= {WIDTH{1'b0}};
      r_tick   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_term && !stop;
      if (w_latch) begin
        r_mode   <= mode;
        r_period <= period;
      end
    end
  end

  assign load   = w_load;
  assign enab   = w_enab;
  assign busy   = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign cnt_in = {WIDTH{1'b0}};
  assign tick   = r_tick;

endmodule
